// File: rtl/mod_down_timer.sv
// ---------------------------------------------------------------------------
// mod_down_timer
//   Programmable modulo down-counter / interval timer. A loaded value is
//   counted down to zero. At zero a one-cycle terminal-count pulse is raised.
//   The timer then reloads and keeps running, or it stops and waits for the
//   next start.
//
// Parameters
//   WIDTH        counter width in bits
//   DEFAULT_MOD  reset modulus; count and reload register reset to DEFAULT_MOD-1
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   load         load load_val into count and reload register (highest priority)
//   load_val     value to load
//   start        pulse: IDLE/DONE -> RUN
//   en           count enable, only meaningful in RUN
//   auto_reload  1: reload at terminal count and keep running; 0: stop in DONE
//   Q            current count (registered)
//   tc           terminal-count pulse (registered), one cycle wide
//   busy         high while the timer is in RUN
// ---------------------------------------------------------------------------
module mod_down_timer #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_MOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Next-state logic. Priority is load > start > en.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // A load always parks the timer in IDLE; a start in the same cycle is dropped.
      count_d  = load_val;
      reload_d = load_val;
      state_d  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Count is untouched here; the first decrement happens in RUN.
          if (start) state_d = S_RUN;
        end
        S_DONE: begin
          if (start) begin
            count_d = reload_q;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (en) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end else begin
              // Terminal count: the only route from 0 back to a non-zero value
              // is through the reload register, so the count never underflows.
              tc_d = 1'b1;
              if (auto_reload) count_d = reload_q;
              else             state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: all state, including the reload register, is cleared by the async
  // reset so the timer is fully defined the moment rst deasserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      tc_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values.
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign Q    = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == S_RUN);

endmodule
